// File: rtl/cpu_mem_master.sv
// cpu_mem_master: single-outstanding initiator for the cpu_mem bus.
// A command accepted in IDLE is driven on the bus in REQ until the responder
// pulses cpu_mem_ready or the timeout counter expires, then the result is
// offered on the response channel in RSP until the client takes it.
//
// Handshake rule for both client channels (cmd_*, rsp_*): a transfer happens
// on a rising edge where valid and ready are both high; the initiator keeps
// valid and its payload stable until that edge, and ready never depends
// combinationally on valid.
module cpu_mem_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int TIMEOUT    = 255
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  cpu_mem_valid,
   output logic                  cpu_mem_write,
   output logic [ADDR_WIDTH-1:0] cpu_mem_addr,
   output logic [DATA_WIDTH-1:0] cpu_mem_wdata,
   input  logic [DATA_WIDTH-1:0] cpu_mem_rdata,
   input  logic                  cpu_mem_ready,
   output logic                  busy,
   output logic [7:0]            err_cnt,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   // Counter value on the last cycle the request may stay unanswered.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   // Low while in reset and for the first cycle after release, so that
   // cmd_ready reads 0 during reset and rises on the first clock after it.
   logic                  live_q;

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         live_q    <= 1'b1;
      end
   end

   // Next-state logic: accept in IDLE, wait for ready or timeout in REQ,
   // hold the response in RSP. Inputs outside their state are ignored.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (live_q && cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Ready is checked first so it wins over a coincident timeout.
            if (cpu_mem_ready) begin
               rdata_d = write_q ? '0 : cpu_mem_rdata;
               err_d   = 1'b0;
               state_d = RSP;
            end else if (cnt_q == TMO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are decoded from registers only.
   always_comb begin
      cmd_ready     = live_q && (state_q == IDLE);
      cpu_mem_valid = (state_q == REQ);
      rsp_valid     = (state_q == RSP);
      cpu_mem_write = write_q && (state_q == REQ);
      cpu_mem_addr  = addr_q;
      cpu_mem_wdata = wdata_q;
      rsp_write     = write_q && (state_q == RSP);
      rsp_err       = err_q;
      rsp_rdata     = rdata_q;
      busy          = (state_q != IDLE);
      err_cnt       = err_cnt_q;
      dbg_state     = state_q;
   end

endmodule

// File: doc/cpu_mem_master.md
# cpu_mem_master

Initiator for the CPU memory bus (`cpu_mem_*`) that the memory system's DDR controller serves as responder. It accepts single read/write commands from a client over a valid/ready command channel and drives one bus transaction at a time, holding the request stable until the responder's `cpu_mem_ready`. It captures read data and returns a response, with error status, on a valid/ready response channel. A timeout counter aborts requests the responder never completes.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 64, data width
- `TIMEOUT`, 255, max cycles `cpu_mem_valid` is held without ready (legal range 1..65535)
- `sys_clk`  in  1  clock; all logic on rising edge
- `sys_rst_n`  in  1  reset; asynchronous, active-low
- `cmd_valid`  in  1  client command valid
- `cmd_ready`  out  1  block can accept a command
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WIDTH  command address
- `cmd_wdata`  in  DATA_WIDTH  write data
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  client accepts response
- `rsp_write`  out  1  response belongs to a write
- `rsp_err`  out  1  transaction timed out
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors
- `cpu_mem_valid`  out  1  bus request valid
- `cpu_mem_write`  out  1  bus write strobe
- `cpu_mem_addr`  out  ADDR_WIDTH  bus address
- `cpu_mem_wdata`  out  DATA_WIDTH  bus write data
- `cpu_mem_rdata`  in  DATA_WIDTH  bus read data; valid in the cycle `cpu_mem_ready` is high
- `cpu_mem_ready`  in  1  responder completion; one-cycle pulse
- `busy`  out  1  state != IDLE
- `err_cnt`  out  8  timeout count, saturating at 255

## Operation
- States: IDLE, REQ, RSP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`: register `cmd_write`/`cmd_addr`/`cmd_wdata` into the bus outputs, clear the timeout counter, go to REQ.
- **REQ:**
  - `cpu_mem_valid`=1. Addr/wdata/write are held constant for the whole state.
  - Counter increments each cycle `cpu_mem_ready`=0.
  - On `cpu_mem_ready`=1: capture `cpu_mem_rdata` (reads only; writes capture 0), set `rsp_err`=0, go to RSP.
  - On counter == TIMEOUT-1 with ready low: set `rsp_err`=1, `rsp_rdata`=0, increment `err_cnt` (saturating), go to RSP.
  - If ready and the timeout condition occur in the same cycle, ready wins: normal completion, no error.
- **RSP:**
  - `rsp_valid`=1. `rsp_write`/`rsp_err`/`rsp_rdata` are stable.
  - On `rsp_ready`: go to IDLE.
- `cpu_mem_ready` outside REQ is ignored: no state change, no capture.
- `cmd_valid` outside IDLE is not accepted and causes no side effect.
- `cmd_ready`, `cpu_mem_valid` and `rsp_valid` are mutually exclusive and decoded from the state register.
- Reset, including mid-transaction:
  - All outputs go to 0 immediately and state goes to IDLE.
  - The in-flight transaction is dropped with no response.
  - `err_cnt` clears.
  - After reset release, `cmd_ready`=1 on the first clock.

## Timing
- Command handshake at edge N → `cpu_mem_valid`=1 from cycle N+1.
- `cpu_mem_ready` sampled high at edge M → `cpu_mem_valid`=0 and `rsp_valid`=1 from M+1.
- `rsp_ready` sampled high at edge K → `rsp_valid`=0 and `cmd_ready`=1 from K+1.
- Minimum cycle: with ready returned the first REQ cycle and `rsp_ready` tied high, one transaction every 3 cycles.
- Timeout: `cpu_mem_valid` is high for exactly TIMEOUT cycles, then `rsp_valid` rises the next cycle.
- No combinational path from any input to any output.

## Test plan
- **Reset values:** assert `sys_rst_n`=0 asynchronously mid-cycle → all outputs 0 at once; release → `cmd_ready`=1 on the next edge.
- **Single write:** write addr 0x1000, wdata 0xDEADBEEF_CAFEF00D; ready after 3 cycles → bus fields stable for all 3 cycles, then response `rsp_write`=1, `rsp_err`=0, `rsp_rdata`=0.
- **Read:** read 0x2000; responder returns 0x0123456789ABCDEF with ready on the first REQ cycle; `rsp_ready` tied 1 → `rsp_rdata`=0x0123456789ABCDEF, next `cmd_ready` 3 cycles after the command handshake.
- **Timeout:** TIMEOUT=4, never assert ready → `cpu_mem_valid` high exactly 4 cycles, `rsp_err`=1, `err_cnt`=1. Repeat 300 times → `err_cnt` saturates at 255.
- **Boundary cases:**
  - Ready arrives in the same cycle as the timeout → `rsp_err`=0 and the data is captured.
  - Spurious ready in IDLE or RSP → no effect.
  - `cmd_valid` held during RSP → not accepted until the cycle after `rsp_ready`.
- **Backpressure and reset:** hold `rsp_ready`=0 for 10 cycles → response fields stable, no new command accepted. Assert reset in REQ → no response is produced and `err_cnt`=0.
